// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// requester ids and the default response timeout.
package mem_arbiter_pkg;

   // Access sequencing: wait for a request, hold it on the memory bus, then
   // hand the captured result back to the requester.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   // Requester ids; the id register and last_grant use this one-bit encoding.
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // Wait counter width and the default number of ISSUE cycles allowed
   // before an access is abandoned (legal range 1..255).
   localparam int WAIT_W          = 8;
   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick between the fetch and data requesters.
// On a tie the requester that was not granted last wins; a lone request
// always wins. The output is only meaningful while at least one request is high.
module arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic req_if_i,
   input  logic req_d_i,
   input  logic last_grant_i,
   output logic grant_o
);

   // Pick the winner from the current requests and the previous grant.
   always_comb begin
      // NOTE: every output of a combinational block gets a value before any
      // branch, so no path leaves it unassigned and no latch is inferred.
      grant_o = REQ_IF;
      if (req_if_i && req_d_i) begin
         grant_o = ~last_grant_i;
      end else if (req_d_i) begin
         grant_o = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a
// data load/store port. At most one access is outstanding; each access goes
// IDLE -> ISSUE (bus driven until mem_ready or timeout) -> RESP (one-cycle
// valid pulse) -> IDLE, giving a best case of one access every three cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   // data load/store port
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   // shared memory port
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   // status
   output logic              stall,
   output logic              err
);

   // The wait counter hits TIMEOUT on the cycle it would otherwise advance
   // past TIMEOUT-1, so comparing against TIMEOUT-1 ends ISSUE after exactly
   // TIMEOUT cycles without mem_ready.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e              state_q,      state_d;
   logic                id_q,         id_d;
   logic                last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   logic                wr_q,         wr_d;
   logic [DATA_W-1:0]   wdata_q,      wdata_d;
   logic [WAIT_W-1:0]   wait_q,       wait_d;
   logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
   logic                err_q,        err_d;

   logic                grant;
   logic                issuing;

   arb_rr2 u_arb (
      .req_if_i     (if_req),
      .req_d_i      (d_req),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // Next-state logic: arbitration and latching in IDLE, completion or
   // timeout in ISSUE, and the unconditional return from RESP.
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wr_d         = wr_q;
      wdata_d      = wdata_q;
      wait_d       = wait_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      err_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               id_d         = grant;
               last_grant_d = grant;
               wait_d       = '0;
               state_d      = ISSUE;
               if (grant == REQ_D) begin
                  addr_d  = d_addr;
                  wr_d    = d_wr;
                  wdata_d = d_wdata;
               end else begin
                  // Fetches are always reads.
                  addr_d  = if_addr;
                  wr_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end

         ISSUE: begin
            if (mem_ready) begin
               state_d = RESP;
               if (id_q == REQ_IF) begin
                  if_rdata_d = mem_rdata;
               end else begin
                  d_rdata_d = wr_q ? '0 : mem_rdata;
               end
            end else if (wait_q == WAIT_LAST) begin
               // Memory never answered: drop the access and flag it. The
               // requester still holds its request and is re-arbitrated.
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge value of every other flop.
      if (!rst) begin
         // NOTE: the latched request and read-data registers are cleared
         // too, because they drive outputs that must read 0 after reset.
         state_q      <= IDLE;
         id_q         <= REQ_IF;
         last_grant_q <= REQ_IF;
         addr_q       <= '0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         wait_q       <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         wait_q       <= wait_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_q        <= err_d;
      end
   end

   // Output decode: the memory bus is idle (all zero) outside ISSUE.
   always_comb begin
      issuing   = (state_q == ISSUE);
      mem_en    = issuing;
      mem_wr    = issuing & wr_q;
      mem_addr  = issuing ? addr_q  : '0;
      mem_wdata = issuing ? wdata_q : '0;
      if_valid  = (state_q == RESP) && (id_q == REQ_IF);
      d_valid   = (state_q == RESP) && (id_q == REQ_D);
      if_rdata  = if_rdata_q;
      d_rdata   = d_rdata_q;
      err       = err_q;
      stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory checked every cycle
// against a transaction-level model. A second instance with a short timeout
// covers the timeout scenario.
module tb_mem_arbiter;

   localparam int MAIN_TO  = 8;
   localparam int SHORT_TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        if_req, if_valid, d_req, d_wr, d_valid;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic        mem_en, mem_wr, mem_ready, stall, err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        t_if_req, t_if_valid, t_d_req, t_d_wr, t_d_valid;
   logic [31:0] t_if_addr, t_if_rdata, t_d_addr, t_d_wdata, t_d_rdata;
   logic        t_mem_en, t_mem_wr, t_mem_ready, t_stall, t_err;
   logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(MAIN_TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall), .err(err)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(SHORT_TO)) dut_to (
      .clk(clk), .rst(rst),
      .if_req(t_if_req), .if_addr(t_if_addr), .if_valid(t_if_valid), .if_rdata(t_if_rdata),
      .d_req(t_d_req), .d_wr(t_d_wr), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
      .d_valid(t_d_valid), .d_rdata(t_d_rdata),
      .mem_en(t_mem_en), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
      .mem_rdata(t_mem_rdata), .mem_ready(t_mem_ready),
      .stall(t_stall), .err(t_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transaction-level model of the main instance.
   // m_busy: an access is on the memory bus; m_done: who gets a result this
   // cycle (-1 none, 0 fetch, 1 data); m_wait: ISSUE cycles without ready.
   // ---------------------------------------------------------------------
   bit          m_busy;
   int          m_done;
   int          m_wait;
   int          m_who;
   int          m_last;
   bit          m_err;
   bit          m_wr;
   logic [31:0] m_addr, m_wdata, m_if_data, m_d_data;

   task automatic model_step();
      if (!rst) begin
         m_busy = 0; m_done = -1; m_wait = 0; m_who = 0; m_last = 0; m_err = 0;
         m_wr = 0; m_addr = 0; m_wdata = 0; m_if_data = 0; m_d_data = 0;
         return;
      end
      m_err = 0;
      if (m_done != -1) begin
         m_done = -1;                       // result handed over, bus free again
      end else if (m_busy) begin
         if (mem_ready) begin
            if (m_who == 0) m_if_data = mem_rdata;
            else            m_d_data  = m_wr ? 32'h0 : mem_rdata;
            m_done = m_who;
            m_busy = 0;
         end else begin
            m_wait++;
            if (m_wait >= MAIN_TO) begin
               m_busy = 0;
               m_err  = 1;
            end
         end
      end else if (if_req || d_req) begin
         if (if_req && d_req) m_who = 1 - m_last;
         else                 m_who = d_req ? 1 : 0;
         m_last  = m_who;
         m_busy  = 1;
         m_wait  = 0;
         m_addr  = (m_who == 1) ? d_addr : if_addr;
         m_wr    = (m_who == 1) ? d_wr : 1'b0;
         m_wdata = d_wdata;
      end
   endtask

   // Compare process: advance the model on each edge with the inputs the DUT
   // sampled, then check every output shortly after the edge.
   always @(posedge clk) begin
      model_step();
      #1;
      check("mdl_mem_en",   mem_en,   m_busy);
      check("mdl_mem_wr",   mem_wr,   m_busy & m_wr);
      check("mdl_mem_addr", mem_addr, m_busy ? m_addr : 32'h0);
      if (!m_busy || m_who == 1)
         check("mdl_mem_wdata", mem_wdata, m_busy ? m_wdata : 32'h0);
      check("mdl_if_valid", if_valid, m_done == 0);
      check("mdl_d_valid",  d_valid,  m_done == 1);
      check("mdl_if_rdata", if_rdata, m_if_data);
      check("mdl_d_rdata",  d_rdata,  m_d_data);
      check("mdl_err",      err,      m_err);
      check("mdl_stall",    stall,    (if_req & (m_done != 0)) | (d_req & (m_done != 1)));
   end

   task automatic new_fetch();
      if_req  = 1'b1;
      if_addr = $urandom();
   endtask

   task automatic new_data();
      d_req   = 1'b1;
      d_wr    = 1'($urandom_range(0, 1));
      d_addr  = $urandom();
      d_wdata = $urandom();
   endtask

   initial begin
      int who_q[$];
      int cyc_q[$];
      int cnt;
      int p_ready;

      rst = 1'b0;
      if_req = 0; if_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
      mem_rdata = 0; mem_ready = 0;
      t_if_req = 0; t_if_addr = 0; t_d_req = 0; t_d_wr = 0; t_d_addr = 0; t_d_wdata = 0;
      t_mem_rdata = 0; t_mem_ready = 0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst_mem_en",   mem_en,   0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_d_valid",  d_valid,  0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata",  d_rdata,  0);
      check("rst_err",      err,      0);
      check("rst_stall",    stall,    0);

      // ---- single fetch, memory ready in the first ISSUE cycle ----
      // mem_ready is already high while idle; it must be ignored there.
      rst = 1'b1;
      if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("f_mem_en",   mem_en,   1);
      check("f_mem_wr",   mem_wr,   0);
      check("f_mem_addr", mem_addr, 32'h100);
      check("f_stall",    stall,    1);
      @(negedge clk);
      check("f_if_valid", if_valid, 1);
      check("f_if_rdata", if_rdata, 32'hDEADBEEF);
      check("f_d_valid",  d_valid,  0);
      check("f_stall_v",  stall,    0);
      check("f_pin_mdl",  m_if_data, 32'hDEADBEEF);
      if_req = 0; mem_ready = 0;
      @(negedge clk);
      check("f_valid_off", if_valid, 0);
      check("f_hold",      if_rdata, 32'hDEADBEEF);

      // ---- tie from reset: data first, then alternation every 3 cycles ----
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      if_req = 1; d_req = 1; if_addr = 32'h200; d_addr = 32'h300; d_wr = 0;
      mem_ready = 1; mem_rdata = 32'hA5A50001;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (if_valid) begin who_q.push_back(0); cyc_q.push_back(c); end
         if (d_valid)  begin who_q.push_back(1); cyc_q.push_back(c); end
      end
      if_req = 0; d_req = 0;
      check("tie_count", who_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check("tie_order", (k < who_q.size()) ? who_q[k] : -1, (k % 2 == 0) ? 1 : 0);
         check("tie_cycle", (k < cyc_q.size()) ? cyc_q[k] : -1, 2 + 3 * k);
      end
      @(negedge clk);

      // ---- store ----
      d_req = 1; d_wr = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
      mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("s_mem_en",    mem_en,    1);
      check("s_mem_wr",    mem_wr,    1);
      check("s_mem_addr",  mem_addr,  32'h40);
      check("s_mem_wdata", mem_wdata, 32'h12345678);
      @(negedge clk);
      check("s_d_valid",  d_valid,  1);
      check("s_d_rdata",  d_rdata,  0);
      check("s_if_valid", if_valid, 0);
      check("s_pin_mdl",  m_d_data, 0);
      d_req = 0; d_wr = 0; mem_ready = 0;
      @(negedge clk);

      // ---- slow memory: ready only in the sixth ISSUE cycle ----
      if_req = 1; if_addr = 32'h5550; mem_ready = 0; mem_rdata = 32'h0BADF00D;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("slow_mem_en",   mem_en,   1);
         check("slow_mem_addr", mem_addr, 32'h5550);
         check("slow_stall",    stall,    1);
         cnt += int'(if_valid);
         if (i == 5) mem_ready = 1;
      end
      @(negedge clk);
      check("slow_if_valid", if_valid, 1);
      check("slow_if_rdata", if_rdata, 32'h0BADF00D);
      if_req = 0; mem_ready = 0;
      repeat (3) begin
         @(negedge clk);
         cnt += int'(if_valid);
      end
      check("slow_one_pulse", cnt, 0);

      // ---- reset in the middle of ISSUE ----
      d_req = 1; d_wr = 0; d_addr = 32'h77; mem_ready = 0;
      repeat (2) @(negedge clk);
      check("rm_in_issue", mem_en, 1);
      rst = 1'b0; d_req = 0;
      @(negedge clk);
      check("rm_mem_en",   mem_en,   0);
      check("rm_mem_addr", mem_addr, 0);
      check("rm_d_valid",  d_valid,  0);
      check("rm_err",      err,      0);
      check("rm_if_rdata", if_rdata, 0);
      check("rm_d_rdata",  d_rdata,  0);
      rst = 1'b1;
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         cnt += int'(if_valid) + int'(d_valid) + int'(err);
      end
      check("rm_no_pulse", cnt, 0);

      // ---- randomized traffic, checked by the compare process ----
      p_ready = 60;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc % 50 == 0) begin
            case ($urandom_range(0, 2))
               0:       p_ready = 70;
               1:       p_ready = 30;
               default: p_ready = 0;   // dead memory: forces timeouts
            endcase
         end
         if (if_req) begin
            if (if_valid) begin
               if ($urandom_range(0, 1) == 1) new_fetch();
               else if_req = 0;
            end
         end else if ($urandom_range(0, 99) < 35) begin
            new_fetch();
         end
         if (d_req) begin
            if (d_valid) begin
               if ($urandom_range(0, 1) == 1) new_data();
               else d_req = 0;
            end
         end else if ($urandom_range(0, 99) < 35) begin
            new_data();
         end
         mem_ready = ($urandom_range(0, 99) < p_ready);
         mem_rdata = $urandom();
         rst = ($urandom_range(0, 499) != 0);
      end
      @(negedge clk);
      rst = 1'b1; if_req = 0; d_req = 0; mem_ready = 0;
      repeat (4) @(negedge clk);

      // ---- timeout on the short-timeout instance ----
      t_d_req = 1; t_d_wr = 0; t_d_addr = 32'h88; t_d_wdata = 32'h99; t_mem_ready = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("to_mem_en",    t_mem_en,    1);
         check("to_mem_addr",  t_mem_addr,  32'h88);
         check("to_mem_wdata", t_mem_wdata, 32'h99);
         check("to_mem_wr",    t_mem_wr,    0);
         check("to_stall",     t_stall,     1);
         cnt += int'(t_err) + int'(t_d_valid) + int'(t_if_valid);
      end
      check("to_no_early", cnt, 0);
      @(negedge clk);
      check("to_err",     t_err,     1);
      check("to_idle",    t_mem_en,  0);
      check("to_d_valid", t_d_valid, 0);
      t_d_req = 0;
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         cnt += int'(t_err) + int'(t_d_valid) + int'(t_if_valid);
      end
      check("to_single",   cnt,        0);
      check("to_d_rdata",  t_d_rdata,  0);
      check("to_if_rdata", t_if_rdata, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
